// File: rtl/bsg_dmc_ui_burst_master.sv
// bsg_dmc_ui_burst_master
//
// Upstream stage for bsg_dmc. Accepts one whole burst per valid/ready
// handshake and turns it into beat-level traffic on the DMC app_* interface.
// Writes are serialized onto the write-data channel. Returning read beats are
// reassembled into full bursts and queued in a small response FIFO. A credit
// counter ensures that every issued read already owns a FIFO slot, because
// the DMC read return cannot be stalled.
//
// Ports
//   clk_i, reset_n_i          UI clock, asynchronous active-low reset
//   init_calib_complete_i     DMC ready; blocks new requests while low
//   cmd_*                     burst request (command, address, data, mask)
//   app_addr/cmd/en/rdy       DMC command channel
//   app_wdf_*                 DMC write-data channel, one beat per transfer
//   app_rd_data_*             DMC read-return beats (never stalled)
//   rd_v/data/ready           reassembled read response burst
//   error_o                   sticky protocol-error flag
//
// Optional feature
//   BSG_DMC_UI_BURST_MASTER_CHECK_EN: enables read-return protocol checking
//   that drives error_o. When undefined, error_o is tied low.

module bsg_dmc_ui_burst_master #(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 32,
  parameter int burst_len_p     = 8,
  parameter int rd_fifo_els_p   = 2
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic                                       init_calib_complete_i,

  input  logic                                       cmd_v_i,
  input  logic                                       cmd_write_i,
  input  logic [ui_addr_width_p-1:0]                 cmd_addr_i,
  input  logic [ui_data_width_p*burst_len_p-1:0]     cmd_data_i,
  input  logic [ui_data_width_p/8*burst_len_p-1:0]   cmd_mask_i,
  output logic                                       cmd_ready_o,

  output logic [ui_addr_width_p-1:0]                 app_addr_o,
  output logic [2:0]                                 app_cmd_o,
  output logic                                       app_en_o,
  input  logic                                       app_rdy_i,

  output logic                                       app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]                 app_wdf_data_o,
  output logic [ui_data_width_p/8-1:0]               app_wdf_mask_o,
  output logic                                       app_wdf_end_o,
  input  logic                                       app_wdf_rdy_i,

  input  logic                                       app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]                 app_rd_data_i,
  input  logic                                       app_rd_data_end_i,

  output logic                                       rd_v_o,
  output logic [ui_data_width_p*burst_len_p-1:0]     rd_data_o,
  input  logic                                       rd_ready_i,

  output logic                                       error_o
);

  localparam int mask_width_lp     = ui_data_width_p/8;
  localparam int burst_width_lp    = ui_data_width_p*burst_len_p;
  localparam int burst_mask_lp     = mask_width_lp*burst_len_p;
  localparam int beat_cnt_width_lp = $clog2(burst_len_p);
  localparam int credit_width_lp   = $clog2(rd_fifo_els_p+1);
  localparam int ptr_width_lp      = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CMD   = 2'b01,
    WDATA = 2'b10
  } state_e;

  state_e state_r, state_s;

  // latched request; beat-indexed packed arrays keep beat 0 in the LSBs
  logic                                           cmd_write_r;
  logic [2:0]                                     app_cmd_r;
  logic [ui_addr_width_p-1:0]                     addr_r;
  logic [burst_len_p-1:0][ui_data_width_p-1:0]    data_r;
  logic [burst_len_p-1:0][mask_width_lp-1:0]      mask_r;

  logic [beat_cnt_width_lp-1:0]                   beat_cnt_r;
  logic [beat_cnt_width_lp-1:0]                   rd_cnt_r;
  logic [burst_len_p-1:0][ui_data_width_p-1:0]    asm_r;
  logic [burst_len_p-1:0][ui_data_width_p-1:0]    enq_data_s;
  logic [credit_width_lp-1:0]                     credits_r;
  logic                                           run_r;

  logic [burst_width_lp-1:0]                      fifo_mem_r [rd_fifo_els_p];
  logic [ptr_width_lp-1:0]                        wr_ptr_r, rd_ptr_r;
  logic [credit_width_lp-1:0]                     fifo_cnt_r;

  logic cmd_accept_s, app_fire_s, wdf_fire_s, rd_cmd_fire_s;
  logic last_beat_s, rd_last_s, enq_s, deq_s, fifo_full_s, credit_avail_s;

  assign last_beat_s    = (beat_cnt_r == beat_cnt_width_lp'(burst_len_p-1));
  assign rd_last_s      = (rd_cnt_r == beat_cnt_width_lp'(burst_len_p-1));
  assign credit_avail_s = (credits_r != credit_width_lp'(0));
  assign fifo_full_s    = (fifo_cnt_r == credit_width_lp'(rd_fifo_els_p));
  assign cmd_accept_s   = cmd_v_i & cmd_ready_o;
  assign app_fire_s     = (state_r == CMD) & app_rdy_i;
  assign wdf_fire_s     = (state_r == WDATA) & app_wdf_rdy_i;
  assign rd_cmd_fire_s  = app_fire_s & ~cmd_write_r;
  assign deq_s          = rd_v_o & rd_ready_i;
  // credits make overflow impossible; the full guard only protects state
  assign enq_s          = app_rd_data_valid_i & rd_last_s & ~fifo_full_s;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
    if (ptr == ptr_width_lp'(rd_fifo_els_p-1)) begin
      return {ptr_width_lp{1'b0}};
    end else begin
      return ptr + ptr_width_lp'(1);
    end
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_s;
  end

  // run_r keeps cmd_ready_o low while reset is held and for the release cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) run_r <= 1'b0;
    else            run_r <= 1'b1;
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_s        = state_r;
    cmd_ready_o    = 1'b0;
    app_en_o       = 1'b0;
    app_wdf_wren_o = 1'b0;
    app_wdf_end_o  = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready_o = run_r & init_calib_complete_i & (cmd_write_i | credit_avail_s);
        if (cmd_v_i & cmd_ready_o) state_s = CMD;
        else                       state_s = IDLE;
      end
      CMD: begin
        app_en_o = 1'b1;
        if (app_rdy_i) state_s = cmd_write_r ? WDATA : IDLE;
        else           state_s = CMD;
      end
      WDATA: begin
        app_wdf_wren_o = 1'b1;
        app_wdf_end_o  = last_beat_s;
        if (app_wdf_rdy_i & last_beat_s) state_s = IDLE;
        else                             state_s = WDATA;
      end
      default: state_s = IDLE;
    endcase
  end

  // capture the whole request at acceptance; held stable until the next one
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_write_r <= 1'b0;
      app_cmd_r   <= 3'b000;
      addr_r      <= {ui_addr_width_p{1'b0}};
      data_r      <= {burst_width_lp{1'b0}};
      mask_r      <= {burst_mask_lp{1'b0}};
    end else if (cmd_accept_s) begin
      cmd_write_r <= cmd_write_i;
      app_cmd_r   <= cmd_write_i ? 3'b000 : 3'b001;
      addr_r      <= cmd_addr_i;
      data_r      <= cmd_data_i;
      mask_r      <= cmd_mask_i;
    end
  end

  // write-beat counter, cleared on entry to WDATA
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)      beat_cnt_r <= {beat_cnt_width_lp{1'b0}};
    else if (app_fire_s) beat_cnt_r <= {beat_cnt_width_lp{1'b0}};
    else if (wdf_fire_s) beat_cnt_r <= last_beat_s ? {beat_cnt_width_lp{1'b0}}
                                                   : beat_cnt_r + beat_cnt_width_lp'(1);
  end

  // read credits: a slot is claimed when a read is issued, released on dequeue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_r <= credit_width_lp'(rd_fifo_els_p);
    end else begin
      case ({rd_cmd_fire_s, deq_s})
        2'b10:   credits_r <= credits_r - credit_width_lp'(1);
        2'b01:   credits_r <= credits_r + credit_width_lp'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  // read assembly: each returning beat lands in slot rd_cnt_r
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_cnt_r <= {beat_cnt_width_lp{1'b0}};
      asm_r    <= {burst_width_lp{1'b0}};
    end else if (app_rd_data_valid_i) begin
      asm_r[rd_cnt_r] <= app_rd_data_i;
      rd_cnt_r        <= rd_last_s ? {beat_cnt_width_lp{1'b0}}
                                   : rd_cnt_r + beat_cnt_width_lp'(1);
    end
  end

  // the final beat bypasses the assembly register straight into the FIFO
  always_comb begin
    enq_data_s                = asm_r;
    enq_data_s[burst_len_p-1] = app_rd_data_i;
  end

  for (genvar g = 0; g < rd_fifo_els_p; g++) begin : g_fifo
    // response FIFO storage entry
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)                                    fifo_mem_r[g] <= {burst_width_lp{1'b0}};
      else if (enq_s && wr_ptr_r == ptr_width_lp'(g))    fifo_mem_r[g] <= enq_data_s;
    end
  end

  // response FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r   <= {ptr_width_lp{1'b0}};
      rd_ptr_r   <= {ptr_width_lp{1'b0}};
      fifo_cnt_r <= {credit_width_lp{1'b0}};
    end else begin
      if (enq_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({enq_s, deq_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + credit_width_lp'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - credit_width_lp'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  assign app_cmd_o      = app_cmd_r;
  assign app_addr_o     = addr_r;
  assign app_wdf_data_o = data_r[beat_cnt_r];
  assign app_wdf_mask_o = mask_r[beat_cnt_r];
  assign rd_v_o         = (fifo_cnt_r != credit_width_lp'(0));
  assign rd_data_o      = fifo_mem_r[rd_ptr_r];

`ifdef BSG_DMC_UI_BURST_MASTER_CHECK_EN
  logic error_r;

  // sticky error: misplaced end marker, or a beat with no read outstanding
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if (app_rd_data_valid_i &&
                 ((app_rd_data_end_i != rd_last_s) ||
                  (credits_r == credit_width_lp'(rd_fifo_els_p)))) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  logic unused_end_s;
  assign unused_end_s = app_rd_data_end_i;
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_dmc_ui_burst_master.sv
// Self-checking bench for bsg_dmc_ui_burst_master: directed scenarios followed
// by randomized traffic, compared against a transaction-level queue model.
module tb_bsg_dmc_ui_burst_master;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int FE = 2;

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic           init_calib_complete_i;
  logic           cmd_v_i, cmd_write_i;
  logic [AW-1:0]  cmd_addr_i;
  logic [255:0]   cmd_data_i;
  logic [31:0]    cmd_mask_i;
  logic           cmd_ready_o;
  logic [AW-1:0]  app_addr_o;
  logic [2:0]     app_cmd_o;
  logic           app_en_o, app_rdy_i;
  logic           app_wdf_wren_o;
  logic [31:0]    app_wdf_data_o;
  logic [3:0]     app_wdf_mask_o;
  logic           app_wdf_end_o, app_wdf_rdy_i;
  logic           app_rd_data_valid_i;
  logic [31:0]    app_rd_data_i;
  logic           app_rd_data_end_i;
  logic           rd_v_o;
  logic [255:0]   rd_data_o;
  logic           rd_ready_i;
  logic           error_o;

  bsg_dmc_ui_burst_master #(
    .ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_len_p(BL), .rd_fifo_els_p(FE)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .init_calib_complete_i(init_calib_complete_i),
    .cmd_v_i(cmd_v_i), .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_data_i(cmd_data_i), .cmd_mask_i(cmd_mask_i), .cmd_ready_o(cmd_ready_o),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
    .app_rd_data_end_i(app_rd_data_end_i),
    .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic write; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [31:0] data; logic [3:0] mask; logic last; } beat_t;

  cmd_t         cmdq[$];      // accepted, command not yet issued to DMC
  beat_t        wbq[$];       // write beats not yet transferred
  logic [255:0] pend_q[$];    // issued reads whose data is still returning
  logic [255:0] done_q[$];    // complete bursts awaiting dequeue
  int           ret_idx = 0;
  int           reads_out = 0;
  bit           alive = 0;
  bit           exp_err = 0;
  bit           force_rd = 0;
  logic [255:0] forced_burst;
  int           corrupt_idx = -1;
  int           n_accepts = 0;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    cmdq.delete(); wbq.delete(); pend_q.delete(); done_q.delete();
    ret_idx = 0; reads_out = 0; exp_err = 0; alive = 0; force_rd = 0; corrupt_idx = -1;
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(input bit v, input bit wr, input logic [AW-1:0] addr,
                      input logic [255:0] data, input logic [31:0] mask,
                      input bit ardy, input bit wrdy, input bit rrdy, input bit ret);
    bit rv, exp_en, exp_wren, exp_ready, hs_app, hs_wdf, acc, deq, bad_end;
    logic [255:0] tmp;
    cmd_t c;
    beat_t b;
    cmd_v_i = v; cmd_write_i = wr; cmd_addr_i = addr; cmd_data_i = data; cmd_mask_i = mask;
    app_rdy_i = ardy; app_wdf_rdy_i = wrdy; rd_ready_i = rrdy;
    rv = ret && (pend_q.size() > 0);
    bad_end = 1'b0;
    app_rd_data_valid_i = rv;
    if (rv) begin
      tmp = pend_q[0];
      bad_end = (ret_idx == corrupt_idx);
      app_rd_data_i = tmp[ret_idx*32 +: 32];
      app_rd_data_end_i = (ret_idx == BL-1) ^ bad_end;
    end else begin
      app_rd_data_i = $urandom;
      app_rd_data_end_i = 1'b0;
    end
    #1;
    exp_en    = (cmdq.size() > 0);
    exp_wren  = (cmdq.size() == 0) && (wbq.size() > 0);
    exp_ready = alive && !exp_en && !exp_wren && init_calib_complete_i && (wr || reads_out < FE);
    check_eq("cmd_ready", cmd_ready_o, exp_ready);
    check_eq("app_en", app_en_o, exp_en);
    if (exp_en) begin
      c = cmdq[0];
      check_eq("app_addr", app_addr_o, c.addr);
      check_eq("app_cmd", app_cmd_o, c.write ? 3'b000 : 3'b001);
    end
    check_eq("wdf_wren", app_wdf_wren_o, exp_wren);
    if (exp_wren) begin
      b = wbq[0];
      check_eq("wdf_data", app_wdf_data_o, b.data);
      check_eq("wdf_mask", app_wdf_mask_o, b.mask);
      check_eq("wdf_end", app_wdf_end_o, b.last);
    end else begin
      check_eq("wdf_end_idle", app_wdf_end_o, 1'b0);
    end
    check_eq("rd_v", rd_v_o, done_q.size() > 0);
    if (done_q.size() > 0) check_eq("rd_data", rd_data_o, done_q[0]);
    check_eq("error", error_o, exp_err);

    hs_app = exp_en && ardy;
    hs_wdf = exp_wren && wrdy;
    acc    = v && exp_ready;
    deq    = (done_q.size() > 0) && rrdy;
    if (deq) begin void'(done_q.pop_front()); reads_out--; end
    if (rv) begin
`ifdef BSG_DMC_UI_BURST_MASTER_CHECK_EN
      if (bad_end) exp_err = 1;
`endif
      if (bad_end) corrupt_idx = -1;
      ret_idx++;
      if (ret_idx == BL) begin done_q.push_back(pend_q.pop_front()); ret_idx = 0; end
    end
    if (hs_app) begin
      c = cmdq.pop_front();
      if (!c.write) begin
        pend_q.push_back(force_rd ? forced_burst : rand256());
        force_rd = 0;
      end
    end
    if (hs_wdf) void'(wbq.pop_front());
    if (acc) begin
      n_accepts++;
      cmdq.push_back('{write: wr, addr: addr});
      if (wr) begin
        for (int i = 0; i < BL; i++)
          wbq.push_back('{data: data[i*32 +: 32], mask: mask[i*4 +: 4], last: (i == BL-1)});
      end else begin
        reads_out++;
      end
    end
    @(posedge clk);
    if (reset_n_i) alive = 1;
    @(negedge clk);
  endtask

  task automatic idle_step(input bit ardy, input bit wrdy, input bit rrdy, input bit ret);
    step(1'b0, 1'b0, '0, '0, '0, ardy, wrdy, rrdy, ret);
  endtask

  logic [255:0] wdata;
  int acc0;

  initial begin
    reset_n_i = 1'b0; init_calib_complete_i = 1'b1; cmd_v_i = 1'b1; cmd_write_i = 1'b1;
    cmd_addr_i = '0; cmd_data_i = '0; cmd_mask_i = '0; app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1;
    app_rd_data_valid_i = 1'b0; app_rd_data_i = '0; app_rd_data_end_i = 1'b0; rd_ready_i = 1'b1;
    forced_burst = '0;
    @(negedge clk);
    // reset state
    check_eq("rst_cmd_ready", cmd_ready_o, 1'b0);
    check_eq("rst_app_en", app_en_o, 1'b0);
    check_eq("rst_app_cmd", app_cmd_o, 3'b000);
    check_eq("rst_app_addr", app_addr_o, '0);
    check_eq("rst_wren", app_wdf_wren_o, 1'b0);
    check_eq("rst_wdata", app_wdf_data_o, '0);
    check_eq("rst_rd_v", rd_v_o, 1'b0);
    check_eq("rst_rd_data", rd_data_o, '0);
    check_eq("rst_error", error_o, 1'b0);
    reset_n_i = 1'b1;
    idle_step(1, 1, 1, 0);

    // write 0x100, beats 0..7, handshakes always ready
    for (int i = 0; i < BL; i++) wdata[i*32 +: 32] = i;
    step(1, 1, 28'h100, wdata, 32'h0, 1, 1, 1, 0);
    for (int k = 0; k < 8; k++) idle_step(1, 1, 1, 0);
    cmd_write_i = 1'b1; #1;
    check_eq("ready_t9", cmd_ready_o, 1'b0);
    idle_step(1, 1, 1, 0);
    cmd_write_i = 1'b1; #1;
    check_eq("ready_t10", cmd_ready_o, 1'b1);

    // write with wdf_rdy toggling
    step(1, 1, 28'h240, rand256(), $urandom, 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) idle_step(1, k[0], 1, 0);

    // three reads, credits limit of two, no dequeue
    acc0 = n_accepts;
    for (int k = 0; k < 8; k++) step(1, 0, 28'h300 + k, '0, '0, 1, 1, 0, 0);
    check_eq("reads_accepted_2", n_accepts - acc0, 2);
    for (int k = 0; k < 24; k++) step(1, 0, 28'h380, '0, '0, 1, 1, 0, 1);
    check_eq("third_read_blocked", n_accepts - acc0, 2);
    check_eq("fifo_full_valid", rd_v_o, 1'b1);
    step(1, 0, 28'h3c0, '0, '0, 1, 1, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 28'h3c0, '0, '0, 1, 1, 0, 1);
    check_eq("third_read_after_deq", n_accepts - acc0, 3);
    for (int k = 0; k < 30; k++) idle_step(1, 1, 1, 1);

    // read returning 0xA0..0xA7
    for (int i = 0; i < BL; i++) forced_burst[i*32 +: 32] = 32'hA0 + i;
    force_rd = 1;
    step(1, 0, 28'h400, '0, '0, 1, 1, 0, 0);
    idle_step(1, 1, 0, 0);
    for (int k = 0; k < BL; k++) idle_step(1, 1, 0, 1);
    check_eq("rd_v_after_last", rd_v_o, 1'b1);
    check_eq("rd_beat0", rd_data_o[31:0], 32'hA0);
    check_eq("rd_beat7", rd_data_o[255:224], 32'hA7);
    idle_step(1, 1, 1, 0);

    // misplaced end marker on beat 3
    step(1, 0, 28'h500, '0, '0, 1, 1, 1, 0);
    corrupt_idx = 3;
    for (int k = 0; k < 12; k++) idle_step(1, 1, 1, 1);
`ifdef BSG_DMC_UI_BURST_MASTER_CHECK_EN
    check_eq("error_sticky", error_o, 1'b1);
`else
    check_eq("error_tied_low", error_o, 1'b0);
`endif

    // reset during write beat 4
    step(1, 1, 28'h600, rand256(), $urandom, 1, 1, 1, 0);
    for (int k = 0; k < 20 && wbq.size() > 4; k++) idle_step(1, 1, 1, 0);
    reset_n_i = 1'b0; #1;
    check_eq("mid_rst_cmd_ready", cmd_ready_o, 1'b0);
    check_eq("mid_rst_app_en", app_en_o, 1'b0);
    check_eq("mid_rst_app_addr", app_addr_o, '0);
    check_eq("mid_rst_wren", app_wdf_wren_o, 1'b0);
    check_eq("mid_rst_wend", app_wdf_end_o, 1'b0);
    check_eq("mid_rst_wdata", app_wdf_data_o, '0);
    check_eq("mid_rst_wmask", app_wdf_mask_o, '0);
    check_eq("mid_rst_rd_v", rd_v_o, 1'b0);
    check_eq("mid_rst_error", error_o, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n_i = 1'b1;
    idle_step(1, 1, 1, 0);
    step(1, 1, 28'h700, rand256(), $urandom, 1, 1, 1, 0);
    for (int k = 0; k < 12; k++) idle_step(1, 1, 1, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      init_calib_complete_i = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom), rand256(), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 1), $urandom_range(0, 9) < 6);
    end
    init_calib_complete_i = 1'b1;
    for (int k = 0; k < 100; k++) idle_step(1, 1, 1, 1);
    check_eq("drain_rd_v", rd_v_o, 1'b0);
    check_eq("drain_app_en", app_en_o, 1'b0);
    check_eq("drain_wren", app_wdf_wren_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_dmc_ui_burst_master.md
# bsg_dmc_ui_burst_master

Upstream stage for `bsg_dmc` that converts whole-burst read/write requests into beat-level transactions on the DMC's Xilinx-style `app_*` interface. It accepts one burst per valid/ready handshake: a command plus `burst_len_p` data words. For writes it serializes the burst onto the write-data channel. For reads it reassembles the returned beats into a full burst and presents it on a backpressurable response port, sized so that the DMC's non-stallable read return can never overflow.

## Interface
- `ui_addr_width_p`, 28, byte address width of `app_addr_o` / `cmd_addr_i`
- `ui_data_width_p`, 32, width of one UI beat
- `burst_len_p`, 8, beats per burst; power of two, ≥ 2
- `rd_fifo_els_p`, 2, depth of the response FIFO in bursts; also the read credit limit

- `clk_i`  in  1  UI clock, same domain as `bsg_dmc` `ui_clk_i`
- `reset_n_i`  in  1  asynchronous, active-low reset
- `init_calib_complete_i`  in  1  DMC ready; no command is accepted while low
- `cmd_v_i`  in  1  request valid
- `cmd_write_i`  in  1  1 = write, 0 = read
- `cmd_addr_i`  in  `ui_addr_width_p`  burst start address
- `cmd_data_i`  in  `ui_data_width_p*burst_len_p`  write data; beat 0 in the LSBs
- `cmd_mask_i`  in  `ui_data_width_p/8*burst_len_p`  byte masks; 1 = masked
- `cmd_ready_o`  out  1  request accepted when `cmd_v_i & cmd_ready_o`
- `app_addr_o`  out  `ui_addr_width_p`  to DMC
- `app_cmd_o`  out  3  3'b000 = write, 3'b001 = read
- `app_en_o`  out  1  command valid
- `app_rdy_i`  in  1  command accepted when `app_en_o & app_rdy_i`
- `app_wdf_wren_o`, `app_wdf_data_o`, `app_wdf_mask_o`, `app_wdf_end_o`  out  1 / `ui_data_width_p` / `ui_data_width_p/8` / 1  write-data beat
- `app_wdf_rdy_i`  in  1  beat accepted when `app_wdf_wren_o & app_wdf_rdy_i`
- `app_rd_data_valid_i`, `app_rd_data_i`, `app_rd_data_end_i`  in  1 / `ui_data_width_p` / 1  read-return beat; cannot be stalled
- `rd_v_o`  out  1  response burst valid
- `rd_data_o`  out  `ui_data_width_p*burst_len_p`  response burst; beat 0 in the LSBs
- `rd_ready_i`  in  1  response consumed when `rd_v_o & rd_ready_i`
- `error_o`  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, CMD, WDATA. Reset state is IDLE.
- IDLE:
  - `cmd_ready_o = init_calib_complete_i & (cmd_write_i | credits > 0)`.
  - On accept, the block latches the command, address, data and mask, then moves to CMD.
- CMD:
  - `app_en_o = 1`; `app_cmd_o` and `app_addr_o` are driven from the latched values.
  - On `app_rdy_i`, a write moves to WDATA with the beat counter at 0.
  - On `app_rdy_i`, a read decrements `credits` and returns to IDLE.
- WDATA:
  - `app_wdf_wren_o = 1`; data and mask come from latched beat `beat_cnt`.
  - `app_wdf_end_o = (beat_cnt == burst_len_p-1)`.
  - Each accepted beat increments `beat_cnt`. Acceptance of the last beat returns the FSM to IDLE.
- Credits:
  - Counter of width `$clog2(rd_fifo_els_p+1)`, reset value `rd_fifo_els_p`.
  - +1 on each response dequeue; −1 on each read command accept.
  - When both events occur in the same cycle, the value is unchanged.
  - This counter guarantees FIFO space for every outstanding read.
- Read assembly:
  - Each `app_rd_data_valid_i` beat is written into slot `rd_cnt` of the assembly register, and `rd_cnt` increments.
  - When `rd_cnt == burst_len_p-1`, the assembled burst is enqueued and `rd_cnt` wraps to 0.
- Response FIFO: `rd_fifo_els_p` entries, first-in first-out, drives `rd_v_o` / `rd_data_o`.
- Reads and writes issue strictly in acceptance order. A read can return while a later write is in WDATA.

## Timing
- Reset values:
  - `cmd_ready_o = 0`, `app_en_o = 0`, `app_wdf_wren_o = 0`, `app_wdf_end_o = 0`, `rd_v_o = 0`, `error_o = 0`.
  - `app_cmd_o`, `app_addr_o`, data, mask and `rd_data_o` all 0.
  - FIFO empty, counters 0, credits full.
- Accept in cycle t → `app_en_o` high in t+1 (registered).
- Write with `app_rdy_i` and `app_wdf_rdy_i` held high: command handshake in t+1, beats in t+2 … t+1+`burst_len_p`, next accept possible in t+2+`burst_len_p`.
- A read accepted in t with `app_rdy_i` high can be followed by the next accept in t+2.
- Last read beat captured in cycle r → `rd_v_o` high in r+1.
- `app_en_o` and `app_wdf_wren_o` never drop until their handshake completes, and the payload is stable while they are held.
- `init_calib_complete_i` falling mid-transaction does not abort CMD or WDATA; it only blocks new accepts.
- `reset_n_i` assertion at any point returns every output to its reset value asynchronously and discards the in-flight burst, the FIFO contents and the counters.

## Configuration
- `BSG_DMC_UI_BURST_MASTER_CHECK_EN` defined:
  - `error_o` sets when `app_rd_data_end_i` disagrees with `(rd_cnt == burst_len_p-1)` on a valid beat.
  - `error_o` also sets when `app_rd_data_valid_i` arrives with `credits == rd_fifo_els_p` (no read outstanding).
  - `error_o` clears only on reset.
- Macro undefined: `error_o` is tied to 0, and the checking logic and `app_rd_data_end_i` are unused.

## Test plan
- Write addr 0x100, data beats 0x0…0x7, mask 0, with `app_rdy_i` and `app_wdf_rdy_i` held 1 → 8 beats in order, `app_wdf_end_o` only on beat 0x7, `cmd_ready_o` high again at t+10.
- `app_wdf_rdy_i` toggling 1,0,1,0 → beats held stable while stalled, exactly 8 transfers, no beat duplicated.
- 3 reads with `rd_fifo_els_p=2` and `rd_ready_i=0` → third read not accepted until one response is dequeued.
- Read returning beats 0xA0…0xA7 → `rd_data_o[31:0]=0xA0` and `[255:224]=0xA7`, `rd_v_o` high the cycle after the last beat.
- Read beat with `app_rd_data_end_i` high on beat 3 (macro defined) → `error_o=1`, held until reset.
- Reset asserted during WDATA beat 4 → all outputs 0 immediately; a new write after release starts again at beat 0.
